// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin Wishbone arbiter: NUM_MASTERS masters share one master port.
//   One transfer per grant, a mandatory IDLE cycle between grants, and a
//   per-transfer watchdog that aborts a stalled slave with an ERR pulse.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_STB,
    input  logic [NUM_MASTERS-1:0]    m_WE,
    input  logic [NUM_MASTERS*AW-1:0] m_ADDR,
    input  logic [NUM_MASTERS*DW-1:0] m_DAT_I,
    output logic [DW-1:0]             m_DAT_O,
    output logic [NUM_MASTERS-1:0]    m_ACK,
    output logic [NUM_MASTERS-1:0]    m_ERR,
    output logic                      s_STB,
    output logic                      s_WE,
    output logic [AW-1:0]             s_ADDR,
    output logic [DW-1:0]             s_DAT_O,
    input  logic [DW-1:0]             s_DAT_I,
    input  logic                      s_ACK,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      busy
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // A width of $clog2(1)=0 is illegal, so a disabled timeout keeps a 1-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam bit                     TO_EN     = (TIMEOUT > 0);
    localparam logic [CW-1:0]          CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]          CNT_MAX   = '1;
    localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);
    localparam logic [IW-1:0]          LAST_INIT = IW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] gidx;       // index of the granted master, mirrors grant
    logic [IW-1:0] last;       // most recent winner; scanning starts just after it
    logic [CW-1:0] cnt;        // cycles spent in BUS without s_ACK

    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    // Round-robin pick: first requester scanning upward from last+1, with wrap.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!pick_valid && m_STB[(int'(last) + 1 + k) % NUM_MASTERS]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(last) + 1 + k) % NUM_MASTERS);
            end
        end
    end

    // Shared-port mux and ACK demux; everything is forced to 0 outside BUS.
    always_comb begin
        s_STB   = 1'b0;
        s_WE    = 1'b0;
        s_ADDR  = '0;
        s_DAT_O = '0;
        m_ACK   = '0;
        if (state == BUS) begin
            s_STB   = m_STB[gidx];
            s_WE    = m_WE[gidx];
            s_ADDR  = m_ADDR[gidx*AW +: AW];
            s_DAT_O = m_DAT_I[gidx*DW +: DW];
            m_ACK   = grant & {NUM_MASTERS{s_ACK}};
        end
    end

    // The ERR state lasts one cycle, so this is a single-cycle pulse to the granted master.
    assign m_ERR   = (state == ERR) ? grant : '0;
    // Read data is broadcast; a master only samples it together with its own m_ACK.
    assign m_DAT_O = s_DAT_I;

    // Arbitration FSM with registered grant and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            last  <= LAST_INIT;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= BUS;
                        grant <= GRANT_ONE << pick_idx;
                        gidx  <= pick_idx;
                        last  <= pick_idx;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                BUS: begin
                    if (s_ACK || !m_STB[gidx]) begin
                        // Completed, or the master gave up: release without ERR.
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (TO_EN && cnt == CNT_LAST) begin
                        state <= ERR;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
//   Cycle table for a 2-master arbiter with TIMEOUT=4: each row sets inputs
//   after the falling edge and checks the outputs before the next rising edge.
//   A hand-written sequence covers asynchronous reset in the middle of a transfer.
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic [AW-1:0] A0   = 32'h1000_0000;
    localparam logic [DW-1:0] D0   = 32'hAAAA_0000;
    localparam logic [AW-1:0] A1   = 32'h0000_0104;
    localparam logic [DW-1:0] D1   = 32'h1234_5678;
    localparam logic [DW-1:0] RDAT = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      m_STB = '0;
    logic [N-1:0]      m_WE = '0;
    logic [N*AW-1:0]   m_ADDR;
    logic [N*DW-1:0]   m_DAT_I;
    logic [DW-1:0]     m_DAT_O;
    logic [N-1:0]      m_ACK;
    logic [N-1:0]      m_ERR;
    logic              s_STB;
    logic              s_WE;
    logic [AW-1:0]     s_ADDR;
    logic [DW-1:0]     s_DAT_O;
    logic [DW-1:0]     s_DAT_I;
    logic              s_ACK = 1'b0;
    logic [N-1:0]      grant;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_STB   (m_STB),
        .m_WE    (m_WE),
        .m_ADDR  (m_ADDR),
        .m_DAT_I (m_DAT_I),
        .m_DAT_O (m_DAT_O),
        .m_ACK   (m_ACK),
        .m_ERR   (m_ERR),
        .s_STB   (s_STB),
        .s_WE    (s_WE),
        .s_ADDR  (s_ADDR),
        .s_DAT_O (s_DAT_O),
        .s_DAT_I (s_DAT_I),
        .s_ACK   (s_ACK),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] stb;
        logic [1:0] we;
        logic       sack;
        logic [1:0] exp_grant;
        logic       exp_bus;    // DUT is in BUS this cycle
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic [1:0] stb, input logic [1:0] we,
                               input logic sack, input logic [1:0] g, input logic bus,
                               input logic [1:0] ack, input logic [1:0] err, input logic bsy);
        vec_t r;
        r.rst = rst; r.stb = stb; r.we = we; r.sack = sack;
        r.exp_grant = g; r.exp_bus = bus; r.exp_ack = ack; r.exp_err = err; r.exp_busy = bsy;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t r, input int i);
        logic          e_stb;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dat;
        @(negedge clk);
        reset = r.rst;
        m_STB = r.stb;
        m_WE  = r.we;
        s_ACK = r.sack;
        #1;
        e_stb  = r.exp_bus && |(r.stb & r.exp_grant);
        e_we   = r.exp_bus && |(r.we & r.exp_grant);
        e_addr = !r.exp_bus ? '0 : (r.exp_grant[1] ? A1 : A0);
        e_dat  = !r.exp_bus ? '0 : (r.exp_grant[1] ? D1 : D0);
        check($sformatf("row%0d grant", i),   grant,   r.exp_grant);
        check($sformatf("row%0d busy", i),    busy,    r.exp_busy);
        check($sformatf("row%0d s_STB", i),   s_STB,   e_stb);
        check($sformatf("row%0d s_WE", i),    s_WE,    e_we);
        check($sformatf("row%0d s_ADDR", i),  s_ADDR,  e_addr);
        check($sformatf("row%0d s_DAT_O", i), s_DAT_O, e_dat);
        check($sformatf("row%0d m_ACK", i),   m_ACK,   r.exp_ack);
        check($sformatf("row%0d m_ERR", i),   m_ERR,   r.exp_err);
        if (r.exp_ack != 2'b00)
            check($sformatf("row%0d m_DAT_O", i), m_DAT_O, RDAT);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_ADDR  = {A1, A0};
        m_DAT_I = {D1, D0};
        s_DAT_I = RDAT;

        //          rst stb    we     ack   grant  bus  m_ACK  m_ERR  busy
        // reset state
        tbl.push_back(v(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        // single request, slave ACKs on the third s_STB cycle
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b01, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b01, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 1, 2'b01, 1, 2'b01, 2'b00, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        // both request after reset: 01,10,01,10 with an IDLE cycle in between
        tbl.push_back(v(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b11, 2'b00, 1, 2'b01, 1, 2'b01, 2'b00, 1));
        tbl.push_back(v(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b11, 2'b00, 1, 2'b10, 1, 2'b10, 2'b00, 1));
        tbl.push_back(v(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b11, 2'b00, 1, 2'b01, 1, 2'b01, 2'b00, 1));
        tbl.push_back(v(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b11, 2'b00, 1, 2'b10, 1, 2'b10, 2'b00, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        // write from master 1
        tbl.push_back(v(0, 2'b10, 2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b10, 2'b10, 0, 2'b10, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b10, 2'b10, 1, 2'b10, 1, 2'b10, 2'b00, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        // ACK on the last cycle before timeout wins over the timeout
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b01, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b01, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b01, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 1, 2'b01, 1, 2'b01, 2'b00, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        // timeout: four s_STB cycles, one ERR cycle (stray ACK ignored), then IDLE
        tbl.push_back(v(0, 2'b10, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b10, 2'b00, 0, 2'b10, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b10, 2'b00, 0, 2'b10, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b10, 2'b00, 0, 2'b10, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b10, 2'b00, 0, 2'b10, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b10, 2'b00, 1, 2'b10, 0, 2'b00, 2'b10, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b00, 2'b00, 0));
        // master drops its strobe mid-transfer: no ACK, no ERR
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b01, 1, 2'b00, 2'b00, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply_row(tbl[i], i);

        // Async reset mid-BUS with master 0 granted (so last=0 before reset).
        @(negedge clk);
        m_STB = 2'b01;
        m_WE  = 2'b00;
        s_ACK = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (grant == 2'b01) break;
        end
        check("rst_seq grant before reset", grant, 2'b01);
        s_ACK = 1'b1;
        #1;
        check("rst_seq m_ACK before reset", m_ACK, 2'b01);
        #1;
        reset = 1'b1;
        #1;
        check("rst_seq grant",   grant,   2'b00);
        check("rst_seq busy",    busy,    1'b0);
        check("rst_seq s_STB",   s_STB,   1'b0);
        check("rst_seq s_WE",    s_WE,    1'b0);
        check("rst_seq s_ADDR",  s_ADDR,  32'h0);
        check("rst_seq s_DAT_O", s_DAT_O, 32'h0);
        check("rst_seq m_ACK",   m_ACK,   2'b00);
        check("rst_seq m_ERR",   m_ERR,   2'b00);
        s_ACK = 1'b0;
        m_STB = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_seq first grant after release", grant, 2'b01);
        check("rst_seq s_ADDR after release", s_ADDR, A0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
